div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sign_fix.sv | 27 ++
 rtl/div_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue controller.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StWb
  } div_state_e;

  localparam int unsigned DivLatencyDefault = 33;
  localparam logic [31:0] DivZeroLo         = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign helper: magnitude of an operand going into the divider and
// conditional two's-complement negation of a result coming out of it.
module div_sign_fix (
  input  logic [31:0] op_i,
  input  logic        signed_i,
  output logic [31:0] abs_o,
  input  logic [31:0] res_i,
  input  logic        neg_i,
  output logic [31:0] res_o
);

  // Negation wraps at 32 bits, so |0x8000_0000| stays 0x8000_0000.
  always_comb begin
    abs_o = op_i;
    if (signed_i && op_i[31]) begin
      abs_o = ~op_i + 32'd1;
    end
  end

  always_comb begin
    res_o = res_i;
    if (neg_i) begin
      res_o = ~res_i + 32'd1;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller for a multi-cycle DIV/DIVU unit with HI/LO registers.
// Signed support is built only when DIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DivLatencyDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        mf_req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam int unsigned    CntW    = $clog2(DIV_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_LATENCY - 1);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic [31:0]     div_a_q, div_a_d;
  logic [31:0]     div_b_q, div_b_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            start_q, start_d;
  logic            dbz_q, dbz_d;

  logic            sgn_mode;
  logic [31:0]     a_mag, b_mag;
  logic [31:0]     quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  assign sgn_mode = div_signed;
`else
  logic unused_div_signed;
  assign unused_div_signed = div_signed;
  assign sgn_mode          = 1'b0;
`endif

  // Operand A path also fixes the quotient; operand B path fixes the remainder.
  div_sign_fix u_fix_a (
    .op_i     (op_a),
    .signed_i (sgn_mode),
    .abs_o    (a_mag),
    .res_i    (quo_q),
    .neg_i    (a_neg_q ^ b_neg_q),
    .res_o    (quo_fix)
  );

  div_sign_fix u_fix_b (
    .op_i     (op_b),
    .signed_i (sgn_mode),
    .abs_o    (b_mag),
    .res_i    (rem_q),
    .neg_i    (a_neg_q),
    .res_o    (rem_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_d = 1'b0;
    dbz_d   = 1'b0;

    // A new request wins in every state, which also aborts any op in flight.
    if (div_req) begin
      cnt_d = '0;
      if (op_b == 32'd0) begin
        hi_d    = op_a;
        lo_d    = DivZeroLo;
        dbz_d   = 1'b1;
        state_d = StIdle;
      end else begin
        div_a_d = a_mag;
        div_b_d = b_mag;
        a_neg_d = sgn_mode & op_a[31];
        b_neg_d = sgn_mode & op_b[31];
        start_d = 1'b1;
        state_d = StRun;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            quo_d   = div_q;
            rem_d   = div_r;
            state_d = StFix;
          end
        end
        StFix: begin
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          state_d = StWb;
        end
        StWb: begin
          hi_d    = rem_q;
          lo_d    = quo_q;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      start_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      start_q <= start_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign stall       = mf_req & busy;
  assign div_start   = start_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider core model.
module tb_div_issue_ctrl;

  localparam int L = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        div_req = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_q, div_r;
  logic        mf_req = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  div_issue_ctrl #(.DIV_LATENCY(L)) dut (
    .clock       (clock),
    .reset       (reset),
    .div_req     (div_req),
    .div_signed  (div_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .div_start   (div_start),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_q       (div_q),
    .div_r       (div_r),
    .mf_req      (mf_req),
    .busy        (busy),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Divider core model: result shows up only once the core has run long enough.
  logic [31:0] core_q, core_r;
  int          core_k = 0;
  always @(posedge clock) begin
    if (div_start) begin
      core_q <= (div_b == 0) ? 32'd0 : div_a / div_b;
      core_r <= (div_b == 0) ? 32'd0 : div_a % div_b;
      core_k <= 1;
    end else if (core_k > 0) begin
      core_k <= core_k + 1;
    end
  end
  assign div_q = (core_k >= L - 1) ? core_q : 32'hDEAD_BEEF;
  assign div_r = (core_k >= L - 1) ? core_r : 32'hBAD0_BAD0;

  function automatic bit sgn_eff(input logic s);
`ifdef DIV_SIGNED_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] v, input logic s);
    longint x;
    x = sgn_eff(s) ? longint'($signed(v)) : longint'(v);
    return (x < 0) ? 32'(-x) : v;
  endfunction

  // MIPS HI/LO result from plain 64-bit arithmetic (truncating division).
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] e_hi, output logic [31:0] e_lo);
    longint sa, sb, q, r;
    if (b == 0) begin
      e_hi = a;
      e_lo = 32'hFFFF_FFFF;
    end else begin
      sa = sgn_eff(s) ? longint'($signed(a)) : longint'(a);
      sb = sgn_eff(s) ? longint'($signed(b)) : longint'(b);
      q = sa / sb;
      r = sa % sb;
      e_lo = 32'(q);
      e_hi = 32'(r);
    end
  endtask

  // Issues one request and watches until the unit is idle again.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int bcyc, output int starts, output int dbzs,
                       output logic [31:0] da, output logic [31:0] db);
    bcyc = 0; starts = 0; dbzs = 0;
    @(negedge clock);
    div_req = 1'b1; op_a = a; op_b = b; div_signed = s;
    @(negedge clock);
    div_req = 1'b0; op_a = $urandom; op_b = $urandom; div_signed = 1'($urandom);
    da = div_a; db = div_b;
    for (int n = 0; n < 200; n++) begin
      if (busy) bcyc++;
      if (div_start) starts++;
      if (div_by_zero) dbzs++;
      if (!busy) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    mf_req = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    n_cmp++; if (div_start !== 1'b0 || div_by_zero !== 1'b0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got start=%b dbz=%b stall=%b want 0", div_start,
                        div_by_zero, stall); end
    n_cmp++; if (div_a !== 32'd0 || div_b !== 32'd0) begin
      n_bad++; $display("FAIL reset_ops: got %h/%h want 0/0", div_a, div_b); end
    mf_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int bc, st, dz;
    logic [31:0] da, db;
    do_op(32'd9, 32'd5, 1'b0, bc, st, dz, da, db);
    n_cmp++; if (hi !== 32'd4 || lo !== 32'd1) begin
      n_bad++; $display("FAIL unsigned_9_5: got hi=%h lo=%h want 4/1", hi, lo); end
    n_cmp++; if (bc !== L + 2) begin
      n_bad++; $display("FAIL unsigned_busy: got %0d want %0d", bc, L + 2); end
    n_cmp++; if (st !== 1 || dz !== 0) begin
      n_bad++; $display("FAIL unsigned_pulses: got start=%0d dbz=%0d want 1/0", st, dz); end
    n_cmp++; if (da !== 32'd9 || db !== 32'd5) begin
      n_bad++; $display("FAIL unsigned_ops: got %h/%h want 9/5", da, db); end
  endtask

  task automatic test_signed;
    int bc, st, dz;
    logic [31:0] da, db, e_hi, e_lo;
    logic [31:0] av[2];
    logic [31:0] bv[2];
    av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;
    av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      do_op(av[i], bv[i], 1'b1, bc, st, dz, da, db);
      ref_div(av[i], bv[i], 1'b1, e_hi, e_lo);
      n_cmp++; if (hi !== e_hi || lo !== e_lo) begin
        n_bad++; $display("FAIL signed_%0d: got hi=%h lo=%h want %h/%h", i, hi, lo, e_hi, e_lo);
      end
      n_cmp++; if (da !== ref_mag(av[i], 1'b1) || db !== ref_mag(bv[i], 1'b1)) begin
        n_bad++; $display("FAIL signed_mag_%0d: got %h/%h want %h/%h", i, da, db,
                          ref_mag(av[i], 1'b1), ref_mag(bv[i], 1'b1));
      end
    end
  endtask

  task automatic test_div_zero;
    int bc, st, dz;
    logic [31:0] da, db;
    do_op(32'd123, 32'd0, 1'b0, bc, st, dz, da, db);
    n_cmp++; if (hi !== 32'd123 || lo !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL dz_result: got hi=%h lo=%h want 7b/ffffffff", hi, lo); end
    n_cmp++; if (dz !== 1 || st !== 0 || bc !== 0) begin
      n_bad++; $display("FAIL dz_flags: got dbz=%0d start=%0d busy=%0d want 1/0/0", dz, st, bc);
    end
    @(negedge clock);
    n_cmp++; if (div_by_zero !== 1'b0 || div_start !== 1'b0) begin
      n_bad++; $display("FAIL dz_pulse: got dbz=%b start=%b want 0/0", div_by_zero, div_start);
    end
  endtask

  task automatic test_stall;
    int stall_hi = 0;
    @(negedge clock);
    div_req = 1'b1; op_a = 32'd50; op_b = 32'd6; div_signed = 1'b0;
    @(negedge clock);
    div_req = 1'b0;
    for (int cyc = 1; cyc <= L + 3; cyc++) begin
      if (cyc == 3) begin
        n_cmp++; if (stall !== 1'b0) begin
          n_bad++; $display("FAIL stall_early: got %b want 0", stall); end
      end
      if (cyc == 5) begin
        mf_req = 1'b1;
        #1;
      end
      if (cyc >= 5 && cyc <= L + 2 && stall === 1'b1) stall_hi++;
      if (cyc == L + 3) begin
        n_cmp++; if (stall !== 1'b0 || busy !== 1'b0) begin
          n_bad++; $display("FAIL stall_release: got stall=%b busy=%b want 0/0", stall, busy);
        end
      end
      if (cyc < L + 3) @(negedge clock);
    end
    mf_req = 1'b0;
    n_cmp++; if (stall_hi !== L - 2) begin
      n_bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_hi, L - 2); end
    n_cmp++; if (hi !== 32'd2 || lo !== 32'd8) begin
      n_bad++; $display("FAIL stall_result: got hi=%h lo=%h want 2/8", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int bc, st, dz;
    logic [31:0] da, db;
    @(negedge clock);
    div_req = 1'b1; op_a = 32'd5000; op_b = 32'd3; div_signed = 1'b0;
    @(negedge clock);
    div_req = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_now: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (L + 5) @(negedge clock);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_nowb: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
    do_op(32'd100, 32'd7, 1'b0, bc, st, dz, da, db);
    n_cmp++; if (hi !== 32'd2 || lo !== 32'd14 || bc !== L + 2) begin
      n_bad++; $display("FAIL rstmid_next: got hi=%h lo=%h busy=%0d want 2/e/%0d", hi, lo, bc,
                        L + 2);
    end
  endtask

  task automatic test_back_to_back;
    int bc = 0;
    int changed = 0;
    logic [31:0] hi0, lo0;
    @(negedge clock);
    div_req = 1'b1; op_a = 32'd1000; op_b = 32'd7; div_signed = 1'b0;
    @(negedge clock);
    div_req = 1'b0;
    repeat (10) @(negedge clock);
    hi0 = hi; lo0 = lo;
    div_req = 1'b1; op_a = 32'd20; op_b = 32'd3;
    @(negedge clock);
    div_req = 1'b0; op_a = $urandom; op_b = $urandom;
    n_cmp++; if (div_a !== 32'd20 || div_b !== 32'd3 || div_start !== 1'b1) begin
      n_bad++; $display("FAIL b2b_restart: got %h/%h start=%b want 14/3/1", div_a, div_b,
                        div_start);
    end
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      bc++;
      if (hi !== hi0 || lo !== lo0) changed++;
      if (div_a !== 32'd20 || div_b !== 32'd3) changed++;
      @(negedge clock);
    end
    n_cmp++; if (changed !== 0 || bc !== L + 2) begin
      n_bad++; $display("FAIL b2b_hold: got changes=%0d busy=%0d want 0/%0d", changed, bc, L + 2);
    end
    n_cmp++; if (hi !== 32'd2 || lo !== 32'd6) begin
      n_bad++; $display("FAIL b2b_result: got hi=%h lo=%h want 2/6", hi, lo); end
  endtask

  task automatic test_random;
    int bc, st, dz;
    logic [31:0] a, b, da, db, e_hi, e_lo;
    logic        s;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && i == 0) b = 32'd1;
      do_op(a, b, s, bc, st, dz, da, db);
      ref_div(a, b, s, e_hi, e_lo);
      n_cmp++; if (hi !== e_hi || lo !== e_lo) begin
        n_bad++; $display("FAIL rand_%0d a=%h b=%h s=%b: got hi=%h lo=%h want %h/%h", i, a, b,
                          s, hi, lo, e_hi, e_lo);
      end
      n_cmp++; if (bc !== ((b == 0) ? 0 : L + 2) || dz !== ((b == 0) ? 1 : 0)) begin
        n_bad++; $display("FAIL rand_ctl_%0d: got busy=%0d dbz=%0d", i, bc, dz); end
      if (b != 0) begin
        n_cmp++; if (da !== ref_mag(a, s) || db !== ref_mag(b, s)) begin
          n_bad++; $display("FAIL rand_mag_%0d: got %h/%h want %h/%h", i, da, db,
                            ref_mag(a, s), ref_mag(b, s));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
